player_life_ctrl: RTL and testbench
===================================

# player_life_ctrl

Sequencing controller for the player datapath (the player movement block and the player shot block). It owns the player lifecycle: game start, alive, explosion, respawn with blinking invulnerability, and game over. It gates the left/right keys into the movement block, issues the one-cycle respawn pulse that recentres the player, filters fire requests, and drives visibility and life count to the drawing and score logic. All timing is frame-based, counted on `startOfFrame`.

## Interface
- `INIT_LIVES`, 3: lives loaded at game start; range 1..3.
- `EXPLODE_FRAMES`, 45: frames spent in the explosion; range 1..255.
- `INVULN_FRAMES`, 60: frames of post-respawn invulnerability; range 1..255.
- `BLINK_LOG2`, 2: visibility toggles every 2^BLINK_LOG2 frames during invulnerability.
- `FIRE_COOLDOWN`, 15: minimum frames between two shot requests; range 0..255.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse at each frame start (30 Hz).
- `gameStart` in 1: level signal, game start request; the rising edge is used.
- `plrHit` in 1: player collision, synchronous level.
- `right` in 1: raw right key, level.
- `left` in 1: raw left key, level.
- `fireKey` in 1: raw fire key, level; the rising edge is used.
- `shotActive` in 1: a player shot is already in flight.
- `moveRight` out 1: gated right key to the movement block.
- `moveLeft` out 1: gated left key to the movement block.
- `plrRespawn` out 1: one-cycle pulse that recentres the player (drives the movement block's hit/reset input).
- `shotReq` out 1: one-cycle pulse that launches a shot.
- `plrVisible` out 1: player sprite enable.
- `explodeActive` out 1: selects the explosion sprite.
- `lives` out 2: remaining lives.
- `gameOver` out 1: high while in GAME_OVER.

## Operation
- FSM states: IDLE, ALIVE, EXPLODE, INVULN, GAME_OVER. Reset state is IDLE.
- IDLE or GAME_OVER, on a `gameStart` rising edge:
  - go to INVULN;
  - load `lives` with INIT_LIVES;
  - pulse `plrRespawn`;
  - load the frame counter with INVULN_FRAMES.
- ALIVE, with `plrHit`=1: go to EXPLODE, decrement `lives` (saturates at 0), load the frame counter with EXPLODE_FRAMES.
- EXPLODE, when the frame counter expires:
  - `lives`==0 → GAME_OVER;
  - otherwise → INVULN, pulse `plrRespawn`, load the frame counter with INVULN_FRAMES.
- INVULN: `plrHit` is ignored. When the frame counter expires → ALIVE.
- Frame counter (8 bits):
  - decrements on `startOfFrame` only;
  - "expires" means `startOfFrame` arrives while the count is 1;
  - a load always takes priority over a decrement in the same cycle.
- Movement gating:
  - `moveRight` = `right` & ~`left`, and `moveLeft` = `left` & ~`right`, in ALIVE and INVULN only;
  - both outputs are 0 in every other state;
  - both keys pressed means no movement.
- Fire:
  - `shotReq` pulses on a `fireKey` rising edge when the state is ALIVE or INVULN, `shotActive`=0 and the cooldown counter is 0;
  - `shotReq` loads the cooldown counter with FIRE_COOLDOWN; the counter decrements on `startOfFrame` down to 0;
  - a fire edge that is refused is dropped, not queued.
- Visibility:
  - `plrVisible`=1 in ALIVE;
  - `plrVisible` = frame counter bit [BLINK_LOG2] in INVULN;
  - `plrVisible`=0 otherwise.
- `explodeActive`=1 exactly in EXPLODE. `gameOver`=1 exactly in GAME_OVER.

## Timing
- All outputs are registered. Reset values:
  - `moveRight`, `moveLeft`, `plrRespawn`, `shotReq`, `plrVisible`, `explodeActive`, `gameOver` = 0;
  - `lives` = 0;
  - frame counter and cooldown counter = 0.
- Latency:
  - `plrHit` sampled high → EXPLODE and `lives` decremented one clock later;
  - key edges → `shotReq` one clock after the edge is sampled;
  - key levels → `moveRight`/`moveLeft` one clock later.
- `plrRespawn` and `shotReq` are exactly one clock wide.
- `plrRespawn` is asserted in the same cycle the state register shows INVULN.
- Simultaneous events:
  - `plrHit` and a fire edge in the same ALIVE cycle: the hit wins and no `shotReq` is issued;
  - `plrHit` on the same cycle as INVULN expiry: the state goes to ALIVE and the hit is ignored; a hit still high on the next cycle is taken;
  - `gameStart` in ALIVE, EXPLODE or INVULN is ignored.
- `resetN` mid-operation returns the block to IDLE immediately, clears all counters, and drives all outputs to their reset values. No `plrRespawn` is issued until the next game start.

## Structure
- Package `player_ctrl_pkg`:
  - `plr_state_t` enum (IDLE, ALIVE, EXPLODE, INVULN, GAME_OVER);
  - `FRAME_CNT_W`=8 and `LIVES_W`=2.
- One natural sub-module: `frame_down_counter` (8-bit load and decrement on `startOfFrame`, with an expire flag). It is instantiated twice: once for the state timer and once for the fire cooldown.
- Rising-edge detectors for `gameStart` and `fireKey` are local registers in the top module.

## Test plan
- Reset, then a `gameStart` pulse → `plrRespawn` for 1 clock, `lives`=3, state INVULN. 60 frames later the state is ALIVE and `plrVisible` stays at 1.
- ALIVE with a `plrHit` pulse → `lives` 3→2, `explodeActive`=1 for 45 frames, then one `plrRespawn` pulse and INVULN. A `plrHit` during INVULN leaves `lives` at 2.
- Three hits, each followed by its respawn → after the third explosion `gameOver`=1 and no respawn pulse. A new `gameStart` edge → `lives`=3 and a respawn pulse.
- Fire edges on consecutive frames in ALIVE with `shotActive`=0 → first `shotReq` pulses; the second, 1 frame later, is dropped; a third, 15 frames after the first, is accepted. With `shotActive`=1 no `shotReq` is ever issued.
- `right`=`left`=1 in ALIVE → `moveRight`=`moveLeft`=0. `right` alone in EXPLODE → `moveRight`=0.
- `resetN` asserted in the middle of EXPLODE → all outputs 0 and state IDLE on the same edge. After release, no output activity until `gameStart`.

Source files
------------

// File: rtl/player_ctrl_pkg.sv
// ============================================================================
// player_ctrl_pkg : shared types and widths for the player lifecycle control
// Revision 1.0
// ============================================================================
`default_nettype none

package player_ctrl_pkg;

    localparam int FRAME_CNT_W = 8;
    localparam int LIVES_W     = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ALIVE     = 3'd1,
        EXPLODE   = 3'd2,
        INVULN    = 3'd3,
        GAME_OVER = 3'd4
    } plr_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_down_counter.sv
// ============================================================================
// frame_down_counter : loadable down counter stepped by the frame tick
// Revision 1.0
// ============================================================================
`default_nettype none

module frame_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             expire
);

    // Load wins over a same-cycle tick; the count parks at zero.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (tick && (count != '0)) begin
            count_next = count - 1'b1;
        end
    end

    assign expire = tick && (count == WIDTH'(1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/player_life_ctrl.sv
// ============================================================================
// player_life_ctrl : player lifecycle sequencer (start, explode, respawn, over)
// Revision 1.0
// ============================================================================
`default_nettype none

module player_life_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int INIT_LIVES     = 3,
    parameter int EXPLODE_FRAMES = 45,
    parameter int INVULN_FRAMES  = 60,
    parameter int BLINK_LOG2     = 2,
    parameter int FIRE_COOLDOWN  = 15
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               gameStart,
    input  logic               plrHit,
    input  logic               right,
    input  logic               left,
    input  logic               fireKey,
    input  logic               shotActive,
    output logic               moveRight,
    output logic               moveLeft,
    output logic               plrRespawn,
    output logic               shotReq,
    output logic               plrVisible,
    output logic               explodeActive,
    output logic [LIVES_W-1:0] lives,
    output logic               gameOver
);

    localparam logic [FRAME_CNT_W-1:0] EXPLODE_LOAD = FRAME_CNT_W'(EXPLODE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] INVULN_LOAD  = FRAME_CNT_W'(INVULN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] COOL_LOAD    = FRAME_CNT_W'(FIRE_COOLDOWN);
    localparam logic [LIVES_W-1:0]     LIVES_LOAD   = LIVES_W'(INIT_LIVES);

    plr_state_t             state;
    plr_state_t             state_nxt;
    logic                   game_start_d;
    logic                   fire_key_d;
    logic                   game_start_rise;
    logic                   fire_rise;

    logic                   tmr_load;
    logic [FRAME_CNT_W-1:0] tmr_val;
    logic [FRAME_CNT_W-1:0] tmr_next;
    logic [FRAME_CNT_W-1:0] tmr_count_unused;
    logic                   tmr_expire;

    logic                   cool_load;
    logic [FRAME_CNT_W-1:0] cool_count;
    logic [FRAME_CNT_W-1:0] cool_next_unused;
    logic                   cool_expire_unused;

    logic                   move_right_nxt;
    logic                   move_left_nxt;
    logic                   respawn_nxt;
    logic                   visible_nxt;
    logic [LIVES_W-1:0]     lives_nxt;

    assign game_start_rise = gameStart & ~game_start_d;
    assign fire_rise       = fireKey & ~fire_key_d;

    frame_down_counter #(.WIDTH(FRAME_CNT_W)) u_state_timer (
        .clk        (clk),
        .resetN     (resetN),
        .tick       (startOfFrame),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .count      (tmr_count_unused),
        .count_next (tmr_next),
        .expire     (tmr_expire)
    );

    frame_down_counter #(.WIDTH(FRAME_CNT_W)) u_fire_cooldown (
        .clk        (clk),
        .resetN     (resetN),
        .tick       (startOfFrame),
        .load       (cool_load),
        .load_val   (COOL_LOAD),
        .count      (cool_count),
        .count_next (cool_next_unused),
        .expire     (cool_expire_unused)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            game_start_d <= 1'b0;
            fire_key_d   <= 1'b0;
        end else begin
            state        <= state_nxt;
            game_start_d <= gameStart;
            fire_key_d   <= fireKey;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = INVULN_LOAD;
        case (state)
            IDLE, GAME_OVER: begin
                if (game_start_rise) begin
                    state_nxt = INVULN;
                    tmr_load  = 1'b1;
                end
            end
            ALIVE: begin
                if (plrHit) begin
                    state_nxt = EXPLODE;
                    tmr_load  = 1'b1;
                    tmr_val   = EXPLODE_LOAD;
                end
            end
            EXPLODE: begin
                if (tmr_expire) begin
                    if (lives == '0) begin
                        state_nxt = GAME_OVER;
                    end else begin
                        state_nxt = INVULN;
                        tmr_load  = 1'b1;
                    end
                end
            end
            INVULN: begin
                if (tmr_expire) begin
                    state_nxt = ALIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        respawn_nxt = (state_nxt == INVULN) && (state != INVULN);
        lives_nxt   = lives;
        if ((state == IDLE) || (state == GAME_OVER)) begin
            if (respawn_nxt) begin
                lives_nxt = LIVES_LOAD;
            end
        end else if ((state == ALIVE) && (state_nxt == EXPLODE) && (lives != '0)) begin
            lives_nxt = lives - 1'b1;
        end
        cool_load = fire_rise && ((state == ALIVE) || (state == INVULN)) &&
                    (state_nxt != EXPLODE) && !shotActive && (cool_count == '0);
        move_right_nxt = 1'b0;
        move_left_nxt  = 1'b0;
        if ((state_nxt == ALIVE) || (state_nxt == INVULN)) begin
            move_right_nxt = right & ~left;
            move_left_nxt  = left & ~right;
        end
        visible_nxt = (state_nxt == ALIVE) ||
                      ((state_nxt == INVULN) && tmr_next[BLINK_LOG2]);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            moveRight     <= 1'b0;
            moveLeft      <= 1'b0;
            plrRespawn    <= 1'b0;
            shotReq       <= 1'b0;
            plrVisible    <= 1'b0;
            explodeActive <= 1'b0;
            lives         <= '0;
            gameOver      <= 1'b0;
        end else begin
            moveRight     <= move_right_nxt;
            moveLeft      <= move_left_nxt;
            plrRespawn    <= respawn_nxt;
            shotReq       <= cool_load;
            plrVisible    <= visible_nxt;
            explodeActive <= (state_nxt == EXPLODE);
            lives         <= lives_nxt;
            gameOver      <= (state_nxt == GAME_OVER);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_player_life_ctrl.sv
// ============================================================================
// tb_player_life_ctrl : directed self-checking bench for player_life_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_player_life_ctrl;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       gameStart = 1'b0;
    logic       plrHit = 1'b0;
    logic       right = 1'b0;
    logic       left = 1'b0;
    logic       fireKey = 1'b0;
    logic       shotActive = 1'b0;
    logic       moveRight;
    logic       moveLeft;
    logic       plrRespawn;
    logic       shotReq;
    logic       plrVisible;
    logic       explodeActive;
    logic [1:0] lives;
    logic       gameOver;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;

    player_life_ctrl dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .gameStart     (gameStart),
        .plrHit        (plrHit),
        .right         (right),
        .left          (left),
        .fireKey       (fireKey),
        .shotActive    (shotActive),
        .moveRight     (moveRight),
        .moveLeft      (moveLeft),
        .plrRespawn    (plrRespawn),
        .shotReq       (shotReq),
        .plrVisible    (plrVisible),
        .explodeActive (explodeActive),
        .lives         (lives),
        .gameOver      (gameOver)
    );

    assign outs = {moveRight, moveLeft, plrRespawn, shotReq, plrVisible,
                   explodeActive, lives, gameOver};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick1();
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            tick1();
            cyc();
        end
    endtask

    task automatic fire_try(input string tag, input logic exp);
        fireKey = 1'b1;
        cyc();
        check(tag, 32'(shotReq), 32'(exp));
        fireKey = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset and idle
        cyc(2);
        check("reset_outs", 32'(outs), 32'h0);
        resetN = 1'b1;
        cyc(2);
        check("idle_outs", 32'(outs), 32'h0);

        // Game start: respawn pulse, 3 lives, INVULN loaded with 60 (bit2 set)
        gameStart = 1'b1;
        cyc();
        check("start_respawn", 32'(plrRespawn), 32'd1);
        check("start_lives", 32'(lives), 32'd3);
        check("start_visible", 32'(plrVisible), 32'd1);
        check("start_gameover", 32'(gameOver), 32'd0);
        cyc();
        check("start_respawn_width", 32'(plrRespawn), 32'd0);
        gameStart = 1'b0;

        right = 1'b1;
        cyc();
        check("invuln_move_right", 32'(moveRight), 32'd1);
        right = 1'b0;
        plrHit = 1'b1;
        cyc();
        plrHit = 1'b0;
        check("invuln_hit_lives", 32'(lives), 32'd3);
        check("invuln_hit_explode", 32'(explodeActive), 32'd0);

        // Blink: count 56 has bit2 clear; count 1 likewise
        frames(4);
        check("blink_56", 32'(plrVisible), 32'd0);
        frames(55);
        check("blink_1_still_invuln", 32'(plrVisible), 32'd0);

        // Expiry with a coincident hit: hit ignored, then a held hit is taken
        startOfFrame = 1'b1;
        plrHit = 1'b1;
        cyc();
        startOfFrame = 1'b0;
        check("expiry_alive_visible", 32'(plrVisible), 32'd1);
        check("expiry_hit_ignored", 32'(lives), 32'd3);
        check("expiry_no_explode", 32'(explodeActive), 32'd0);
        cyc();
        plrHit = 1'b0;
        check("held_hit_explode", 32'(explodeActive), 32'd1);
        check("held_hit_lives", 32'(lives), 32'd2);
        check("explode_invisible", 32'(plrVisible), 32'd0);

        // Explosion lasts 45 frames; movement blocked
        right = 1'b1;
        cyc();
        check("explode_move_blocked", 32'(moveRight), 32'd0);
        frames(44);
        check("explode_44", 32'(explodeActive), 32'd1);
        check("explode_44_no_respawn", 32'(plrRespawn), 32'd0);
        tick1();
        check("respawn_pulse", 32'(plrRespawn), 32'd1);
        check("respawn_explode_off", 32'(explodeActive), 32'd0);
        check("respawn_lives", 32'(lives), 32'd2);
        check("respawn_move_right", 32'(moveRight), 32'd1);
        cyc();
        check("respawn_width", 32'(plrRespawn), 32'd0);
        right = 1'b0;

        plrHit = 1'b1;
        cyc();
        plrHit = 1'b0;
        check("invuln2_hit_lives", 32'(lives), 32'd2);
        frames(60);
        check("alive_visible", 32'(plrVisible), 32'd1);
        frames(3);
        check("alive_visible_stays", 32'(plrVisible), 32'd1);

        // Movement gating in ALIVE
        right = 1'b1;
        left  = 1'b1;
        cyc();
        check("both_keys", 32'({moveRight, moveLeft}), 32'd0);
        right = 1'b0;
        cyc();
        check("left_only", 32'({moveRight, moveLeft}), 32'd1);
        left = 1'b0;
        cyc();

        // Fire cooldown of 15 frames
        fire_try("fire_first", 1'b1);
        check("shot_width", 32'(shotReq), 32'd0);
        frames(1);
        fire_try("fire_next_frame", 1'b0);
        frames(13);
        fire_try("fire_cooldown_1", 1'b0);
        frames(1);
        fire_try("fire_cooldown_0", 1'b1);
        frames(15);
        shotActive = 1'b1;
        fire_try("fire_shot_active", 1'b0);
        shotActive = 1'b0;

        // Hit beats a same-cycle fire edge
        plrHit  = 1'b1;
        fireKey = 1'b1;
        cyc();
        plrHit  = 1'b0;
        fireKey = 1'b0;
        check("hit_fire_no_shot", 32'(shotReq), 32'd0);
        check("hit_fire_explode", 32'(explodeActive), 32'd1);
        check("hit_fire_lives", 32'(lives), 32'd1);
        frames(44);
        tick1();
        check("respawn2_pulse", 32'(plrRespawn), 32'd1);
        cyc();
        frames(60);

        // Last life lost -> game over, no respawn
        plrHit = 1'b1;
        cyc();
        plrHit = 1'b0;
        check("hit3_lives", 32'(lives), 32'd0);
        frames(44);
        tick1();
        check("gameover_flag", 32'(gameOver), 32'd1);
        check("gameover_no_respawn", 32'(plrRespawn), 32'd0);
        check("gameover_explode_off", 32'(explodeActive), 32'd0);
        check("gameover_invisible", 32'(plrVisible), 32'd0);
        cyc();
        fire_try("fire_gameover", 1'b0);
        check("gameover_holds", 32'(gameOver), 32'd1);

        // Restart from game over
        gameStart = 1'b1;
        cyc();
        check("restart_respawn", 32'(plrRespawn), 32'd1);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_gameover_off", 32'(gameOver), 32'd0);
        gameStart = 1'b0;
        cyc();
        frames(60);

        // Asynchronous reset in the middle of an explosion
        plrHit = 1'b1;
        cyc();
        plrHit = 1'b0;
        check("pre_reset_explode", 32'(explodeActive), 32'd1);
        right = 1'b1;
        frames(5);
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset_outs", 32'(outs), 32'h0);
        cyc(2);
        resetN = 1'b1;
        frames(3);
        fire_try("fire_after_reset", 1'b0);
        frames(50);
        check("post_reset_quiet", 32'(outs), 32'h0);
        right = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
